clause_eval_sequencer: RTL

//  Sequences one satisfiability check of the current variable assignment over all stored clauses.

---
 rtl/sat_pkg.sv | 17 +
 rtl/clause_eval_sequencer_idx.sv | 26 ++
 rtl/clause_eval_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared types for the clause evaluation sequencer.
// Sequencer state encoding and default clause index width.
package sat_pkg;

  localparam int DEF_NUM_CLAUSES = 64;
  localparam int DEF_IDX_W = $clog2(DEF_NUM_CLAUSES) + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    FINISH
  } seq_state_t;

  typedef logic [DEF_IDX_W-1:0] clause_idx_t;

endpackage

// File: rtl/clause_eval_sequencer_idx.sv
// Clause index counter for the evaluation sequencer.
// Counts 0..NUM_CLAUSES-1 and flags the last clause.
module clause_idx_counter #(
  parameter int NUM_CLAUSES = 64,
  parameter int IDX_W = $clog2(NUM_CLAUSES) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  assign last = (idx == IDX_W'(NUM_CLAUSES - 1));

  // Index register; stops at the last clause so it never goes out of range.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/clause_eval_sequencer.sv
// Walks every stored clause through the evaluator once per check.
// Tracks sticky unsat, first failing index and unsat count.
module clause_eval_sequencer
  import sat_pkg::*;
#(
  parameter int NUM_CLAUSES = 64,
  parameter int IDX_W = $clog2(NUM_CLAUSES) + 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic             clause_req,
  input  logic             clause_ready,
  output logic [IDX_W-1:0] clause_addr,
  input  logic             eval_valid,
  input  logic             eval_unsat,
  output logic             busy,
  output logic             done,
  output logic             result_unsat,
  output logic [IDX_W-1:0] first_unsat_idx,
  output logic [IDX_W-1:0] unsat_count
);

  seq_state_t state;
  seq_state_t next_state;

  logic [IDX_W-1:0] idx;
  logic idx_last;
  logic idx_clear;
  logic idx_inc;
  logic accept;
  logic kill;
  logic unsat_hit;

  assign accept = (state == IDLE) && start && !abort;
  assign kill = abort && (state != IDLE);
  assign unsat_hit = (state == WAIT) && !abort
                     && eval_valid && eval_unsat;
  assign idx_clear = accept || kill;

  assign clause_req = (state == ISSUE);
  assign clause_addr = idx;
  assign busy = (state == ISSUE) || (state == WAIT);
  assign done = (state == FINISH);

  clause_idx_counter #(
    .NUM_CLAUSES(NUM_CLAUSES),
    .IDX_W(IDX_W)
  ) u_idx (
    .clk(clk),
    .reset(reset),
    .clear(idx_clear),
    .inc(idx_inc),
    .idx(idx),
    .last(idx_last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and index advance; abort wins over handshakes.
  always_comb begin
    next_state = state;
    idx_inc = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) next_state = ISSUE;
      end
      ISSUE: begin
        if (abort) next_state = IDLE;
        else if (clause_ready) next_state = WAIT;
      end
      WAIT: begin
        if (abort) begin
          next_state = IDLE;
        end else if (eval_valid) begin
          if (((EARLY_EXIT != 0) && eval_unsat)
              || idx_last) begin
            next_state = FINISH;
          end else begin
            next_state = ISSUE;
            idx_inc = 1'b1;
          end
        end
      end
      FINISH: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Result registers; cleared on a new check or abort, held otherwise.
  always_ff @(posedge clk) begin
    if (reset || accept || kill) begin
      result_unsat <= 1'b0;
      first_unsat_idx <= '0;
      unsat_count <= '0;
    end else if (unsat_hit) begin
      result_unsat <= 1'b1;
      if (!result_unsat) first_unsat_idx <= idx;
      if (unsat_count != {IDX_W{1'b1}}) begin
        unsat_count <= unsat_count + IDX_W'(1);
      end
    end
  end

endmodule
